// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and decode helpers for the load/store unit.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [2:0] SZ_B = 3'b000;
   localparam logic [2:0] SZ_H = 3'b001;
   localparam logic [2:0] SZ_W = 3'b010;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SPLIT = 2'd1,
      DONE  = 2'd2
   } state_e;

   function automatic logic f3_legal(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   // Byte accesses can never be misaligned.
   function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lsb);
      logic mis;
      mis = 1'b0;
      case (f3)
         F3_H, F3_HU: mis = lsb[0];
         F3_W:        mis = (lsb != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of right-justified load data to a full register value.
module load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [2:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] result
);

   always_comb begin
      result = '0;
      case (size)
         SZ_B:    result = is_unsigned ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
         SZ_H:    result = is_unsigned ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
         SZ_W:    result = raw;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/lsu_misalign.sv
// Load/store unit: aligned accesses pass through, misaligned H/W accesses are
// split into byte accesses while the core is stalled.
module lsu_misalign
   import lsu_pkg::*;
#(
   parameter bit          ALLOW_MISALIGNED = 1'b1,
   parameter int unsigned XLEN             = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   input  logic            req_we,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [2:0]      req_funct3,
   output logic            stall,
   output logic [XLEN-1:0] rdata,
   output logic            misaligned,
   output logic            dm_we,
   output logic [XLEN-1:0] dm_a,
   output logic [XLEN-1:0] dm_wd,
   output logic [2:0]      dm_size,
   input  logic [XLEN-1:0] dm_rd
);

   state_e          state_q, state_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] ld_buf_q, ld_buf_d;

   logic            legal;
   logic            is_mis;
   logic            split_start;
   logic [1:0]      last_cnt;
   logic [XLEN-1:0] issue_addr;
   logic [XLEN-1:0] lane_data;
   logic [XLEN-1:0] ext_raw;
   logic [XLEN-1:0] ext_result;
   logic [7:0]      rd_byte;
   logic [7:0]      wr_byte;
   logic [2:0]      acc_size;

   // Request decode; the core holds the request stable for the whole split.
   assign legal       = f3_legal(req_funct3);
   assign is_mis      = addr_misaligned(req_funct3, req_addr[1:0]);
   assign split_start = req_valid && legal && is_mis && ALLOW_MISALIGNED;
   assign last_cnt    = (req_funct3[1:0] == F3_W[1:0]) ? 2'd3 : 2'd1;
   assign issue_addr  = req_addr + XLEN'(cnt_q);
   assign rd_byte     = dm_rd[{issue_addr[1:0], 3'b000} +: 8];
   assign wr_byte     = req_wdata[{cnt_q, 3'b000} +: 8];
   assign lane_data   = dm_rd >> {req_addr[1:0], 3'b000};
   assign acc_size    = {1'b0, req_funct3[1:0]};

   // One extender serves both the passthrough lane and the assembled buffer.
   assign ext_raw = (state_q == DONE) ? ld_buf_q : lane_data;

   load_extend u_load_extend (
      .raw        (ext_raw),
      .size       (acc_size),
      .is_unsigned(req_funct3[2]),
      .result     (ext_result)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ld_buf_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ld_buf_q <= ld_buf_d;
      end
   end

   // Next state, byte counter and load-byte capture.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ld_buf_d = ld_buf_q;
      case (state_q)
         IDLE: begin
            if (split_start) begin
               state_d = SPLIT;
               cnt_d   = 2'd1;
               if (!req_we) ld_buf_d = XLEN'(rd_byte);
            end
         end
         SPLIT: begin
            if (!req_we) ld_buf_d[{cnt_q, 3'b000} +: 8] = rd_byte;
            if (cnt_q == last_cnt) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs; reset forces everything quiet so an in-flight write is dropped.
   always_comb begin
      stall      = 1'b0;
      misaligned = 1'b0;
      dm_we      = 1'b0;
      dm_a       = '0;
      dm_wd      = '0;
      dm_size    = SZ_B;
      rdata      = '0;
      if (!reset) begin
         case (state_q)
            IDLE: begin
               if (req_valid && legal) begin
                  if (is_mis) begin
                     misaligned = 1'b1;
                     if (ALLOW_MISALIGNED) begin
                        stall   = 1'b1;
                        dm_a    = issue_addr;
                        dm_size = SZ_B;
                        dm_wd   = XLEN'(wr_byte);
                        dm_we   = req_we;
                     end
                  end else begin
                     dm_a    = req_addr;
                     dm_size = acc_size;
                     dm_wd   = req_wdata;
                     dm_we   = req_we;
                     rdata   = ext_result;
                  end
               end
            end
            SPLIT: begin
               stall   = 1'b1;
               dm_a    = issue_addr;
               dm_size = SZ_B;
               dm_wd   = XLEN'(wr_byte);
               dm_we   = req_we;
            end
            DONE: begin
               rdata = ext_result;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_misalign.sv
// Directed bench for lsu_misalign with a small byte-addressed data memory model.
module tb_lsu_misalign;
   import lsu_pkg::*;

   localparam logic [31:0] W0 = 32'h44332211;
   localparam logic [31:0] W1 = 32'h88776655;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req_valid, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [2:0]  req_funct3;
   logic        stall, misaligned, dm_we;
   logic [31:0] rdata, dm_a, dm_wd, dm_rd;
   logic [2:0]  dm_size;

   logic        na_req_valid, na_req_we;
   logic [31:0] na_req_addr, na_req_wdata;
   logic [2:0]  na_req_funct3;
   logic        na_stall, na_misaligned, na_dm_we;
   logic [31:0] na_rdata, na_dm_a, na_dm_wd, na_dm_rd;
   logic [2:0]  na_dm_size;

   logic [31:0] mem  [4];
   logic [31:0] mem2 [4];
   logic        preload;

   int n_cmp = 0;
   int n_fail = 0;

   lsu_misalign #(.ALLOW_MISALIGNED(1'b1), .XLEN(32)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
      .stall(stall), .rdata(rdata), .misaligned(misaligned), .dm_we(dm_we),
      .dm_a(dm_a), .dm_wd(dm_wd), .dm_size(dm_size), .dm_rd(dm_rd)
   );

   lsu_misalign #(.ALLOW_MISALIGNED(1'b0), .XLEN(32)) dut_na (
      .clk(clk), .reset(reset), .req_valid(na_req_valid), .req_we(na_req_we),
      .req_addr(na_req_addr), .req_wdata(na_req_wdata), .req_funct3(na_req_funct3),
      .stall(na_stall), .rdata(na_rdata), .misaligned(na_misaligned), .dm_we(na_dm_we),
      .dm_a(na_dm_a), .dm_wd(na_dm_wd), .dm_size(na_dm_size), .dm_rd(na_dm_rd)
   );

   assign dm_rd    = mem[dm_a[3:2]];
   assign na_dm_rd = mem2[na_dm_a[3:2]];

   // Little-endian memory with SB/SH/SW writes; preload restores both images.
   always @(posedge clk) begin
      if (preload) begin
         mem[0] <= W0;  mem[1] <= W1;  mem[2] <= '0;  mem[3] <= '0;
         mem2[0] <= W0; mem2[1] <= W1; mem2[2] <= '0; mem2[3] <= '0;
      end else begin
         if (dm_we) begin
            case (dm_size)
               SZ_B: mem[dm_a[3:2]][{dm_a[1:0], 3'b000} +: 8] <= dm_wd[7:0];
               SZ_H: mem[dm_a[3:2]][{dm_a[1], 4'b0000} +: 16] <= dm_wd[15:0];
               SZ_W: mem[dm_a[3:2]] <= dm_wd;
               default: ;
            endcase
         end
         if (na_dm_we) begin
            case (na_dm_size)
               SZ_B: mem2[na_dm_a[3:2]][{na_dm_a[1:0], 3'b000} +: 8] <= na_dm_wd[7:0];
               SZ_H: mem2[na_dm_a[3:2]][{na_dm_a[1], 4'b0000} +: 16] <= na_dm_wd[15:0];
               SZ_W: mem2[na_dm_a[3:2]] <= na_dm_wd;
               default: ;
            endcase
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3;
   endtask

   task automatic idle();
      req_valid = 1'b0; req_we = 1'b0; na_req_valid = 1'b0; na_req_we = 1'b0;
   endtask

   task automatic preload_mem();
      idle();
      preload = 1'b1;
      tick();
      preload = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      drive(1'b1, 32'h1, 32'hCAFEF00D, F3_W);
      @(negedge clk);
      n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
      n_cmp++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_misaligned: got %b want 0", misaligned); end
      n_cmp++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL reset_dm_we: got %b want 0", dm_we); end
      n_cmp++; if (dm_a !== 32'h0 || dm_wd !== 32'h0 || dm_size !== 3'b000) begin
         n_fail++; $display("FAIL reset_dm_bus: got a=%h wd=%h size=%b want zeros", dm_a, dm_wd, dm_size);
      end
      n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      tick();
      idle();
      reset = 1'b0;
   endtask

   task automatic test_aligned_lw();
      preload_mem();
      drive(1'b0, 32'h0, 32'h0, F3_W);
      @(negedge clk);
      n_cmp++; if (rdata !== 32'h44332211) begin n_fail++; $display("FAIL lw_rdata: got %h want 44332211", rdata); end
      n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lw_stall: got %b want 0", stall); end
      n_cmp++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL lw_misaligned: got %b want 0", misaligned); end
      tick();
      idle();
   endtask

   task automatic test_byte_half();
      logic [31:0] addrs [3] = '{32'h7, 32'h7, 32'h6};
      logic [2:0]  f3s   [3] = '{F3_B, F3_BU, F3_HU};
      logic [31:0] exps  [3] = '{32'hFFFFFF88, 32'h00000088, 32'h00008877};
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, addrs[i], 32'h0, f3s[i]);
         @(negedge clk);
         n_cmp++; if (rdata !== exps[i]) begin n_fail++; $display("FAIL bh_rdata[%0d]: got %h want %h", i, rdata, exps[i]); end
         n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL bh_stall[%0d]: got %b want 0", i, stall); end
         tick();
      end
      idle();
   endtask

   task automatic test_lh_misaligned();
      preload_mem();
      drive(1'b0, 32'h3, 32'h0, F3_H);
      @(negedge clk);
      n_cmp++; if (misaligned !== 1'b1 || stall !== 1'b1) begin
         n_fail++; $display("FAIL lh_first: got mis=%b stall=%b want 1 1", misaligned, stall);
      end
      n_cmp++; if (dm_a !== 32'h3 || dm_size !== 3'b000) begin
         n_fail++; $display("FAIL lh_byte0: got a=%h size=%b want 3 000", dm_a, dm_size);
      end
      tick();
      @(negedge clk);
      n_cmp++; if (misaligned !== 1'b0 || stall !== 1'b1) begin
         n_fail++; $display("FAIL lh_second: got mis=%b stall=%b want 0 1", misaligned, stall);
      end
      n_cmp++; if (dm_a !== 32'h4) begin n_fail++; $display("FAIL lh_byte1: got a=%h want 4", dm_a); end
      tick();
      @(negedge clk);
      n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lh_done_stall: got %b want 0", stall); end
      n_cmp++; if (rdata !== 32'h00005544) begin n_fail++; $display("FAIL lh_rdata: got %h want 00005544", rdata); end
      tick();
      idle();
   endtask

   task automatic test_lw_misaligned();
      int  n_stall = 0;
      logic seen_done = 1'b0;
      preload_mem();
      drive(1'b0, 32'h1, 32'h0, F3_W);
      for (int c = 0; c < 8 && !seen_done; c++) begin
         @(negedge clk);
         if (stall) begin
            n_cmp++; if (dm_a !== 32'(1 + n_stall)) begin
               n_fail++; $display("FAIL lwm_addr[%0d]: got %h want %h", n_stall, dm_a, 32'(1 + n_stall));
            end
            n_stall++;
            tick();
         end else begin
            seen_done = 1'b1;
         end
      end
      n_cmp++; if (!seen_done) begin n_fail++; $display("FAIL lwm_timeout: got stall still high want release"); end
      n_cmp++; if (n_stall !== 4) begin n_fail++; $display("FAIL lwm_stall_cycles: got %0d want 4", n_stall); end
      n_cmp++; if (rdata !== 32'h55443322) begin n_fail++; $display("FAIL lwm_rdata: got %h want 55443322", rdata); end
      tick();
      idle();
   endtask

   task automatic test_sw_misaligned();
      logic [7:0] eb [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      preload_mem();
      drive(1'b1, 32'h2, 32'hDEADBEEF, F3_W);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++; if (stall !== 1'b1 || dm_we !== 1'b1 || dm_size !== 3'b000) begin
            n_fail++; $display("FAIL sw_ctrl[%0d]: got stall=%b we=%b size=%b want 1 1 000", k, stall, dm_we, dm_size);
         end
         n_cmp++; if (dm_a !== 32'(2 + k) || dm_wd[7:0] !== eb[k]) begin
            n_fail++; $display("FAIL sw_byte[%0d]: got a=%h d=%h want a=%h d=%h", k, dm_a, dm_wd[7:0], 32'(2 + k), eb[k]);
         end
         tick();
      end
      @(negedge clk);
      n_cmp++; if (stall !== 1'b0 || dm_we !== 1'b0) begin
         n_fail++; $display("FAIL sw_done: got stall=%b we=%b want 0 0", stall, dm_we);
      end
      tick();
      idle();
      n_cmp++; if (mem[0] !== 32'hBEEF2211) begin n_fail++; $display("FAIL sw_word0: got %h want BEEF2211", mem[0]); end
      n_cmp++; if (mem[1] !== 32'h8877DEAD) begin n_fail++; $display("FAIL sw_word1: got %h want 8877DEAD", mem[1]); end
   endtask

   task automatic test_reset_mid();
      preload_mem();
      drive(1'b1, 32'h1, 32'hCAFEF00D, F3_W);
      @(negedge clk);
      n_cmp++; if (dm_a !== 32'h1 || dm_wd[7:0] !== 8'h0D) begin
         n_fail++; $display("FAIL rm_byte0: got a=%h d=%h want 1 0D", dm_a, dm_wd[7:0]);
      end
      tick();
      @(negedge clk);
      n_cmp++; if (dm_a !== 32'h2 || dm_wd[7:0] !== 8'hF0) begin
         n_fail++; $display("FAIL rm_byte1: got a=%h d=%h want 2 F0", dm_a, dm_wd[7:0]);
      end
      tick();
      reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL rm_we_in_reset: got %b want 0", dm_we); end
      tick();
      reset = 1'b0;
      idle();
      @(negedge clk);
      n_cmp++; if (stall !== 1'b0 || dm_we !== 1'b0) begin
         n_fail++; $display("FAIL rm_after: got stall=%b we=%b want 0 0", stall, dm_we);
      end
      tick();
      n_cmp++; if (mem[0] !== 32'h44F00D11) begin n_fail++; $display("FAIL rm_word0: got %h want 44F00D11", mem[0]); end
      n_cmp++; if (mem[1] !== W1) begin n_fail++; $display("FAIL rm_word1: got %h want %h", mem[1], W1); end
   endtask

   task automatic test_no_misalign();
      preload_mem();
      na_req_valid = 1'b1; na_req_we = 1'b1; na_req_addr = 32'h1;
      na_req_wdata = 32'h00001234; na_req_funct3 = F3_H;
      @(negedge clk);
      n_cmp++; if (na_misaligned !== 1'b1) begin n_fail++; $display("FAIL na_sh_mis: got %b want 1", na_misaligned); end
      n_cmp++; if (na_dm_we !== 1'b0 || na_stall !== 1'b0) begin
         n_fail++; $display("FAIL na_sh_ctrl: got we=%b stall=%b want 0 0", na_dm_we, na_stall);
      end
      tick();
      na_req_we = 1'b0;
      @(negedge clk);
      n_cmp++; if (na_rdata !== 32'h0 || na_stall !== 1'b0 || na_misaligned !== 1'b1) begin
         n_fail++; $display("FAIL na_lh: got rdata=%h stall=%b mis=%b want 0 0 1", na_rdata, na_stall, na_misaligned);
      end
      tick();
      idle();
      n_cmp++; if (mem2[0] !== W0 || mem2[1] !== W1) begin
         n_fail++; $display("FAIL na_mem: got %h %h want %h %h", mem2[0], mem2[1], W0, W1);
      end
   endtask

   task automatic test_illegal();
      preload_mem();
      drive(1'b1, 32'h0, 32'hFFFFFFFF, 3'b011);
      @(negedge clk);
      n_cmp++; if (dm_we !== 1'b0 || stall !== 1'b0) begin
         n_fail++; $display("FAIL ill_store: got we=%b stall=%b want 0 0", dm_we, stall);
      end
      tick();
      drive(1'b0, 32'h0, 32'h0, 3'b110);
      @(negedge clk);
      n_cmp++; if (rdata !== 32'h0 || stall !== 1'b0) begin
         n_fail++; $display("FAIL ill_load: got rdata=%h stall=%b want 0 0", rdata, stall);
      end
      tick();
      idle();
      n_cmp++; if (mem[0] !== W0) begin n_fail++; $display("FAIL ill_mem: got %h want %h", mem[0], W0); end
   endtask

   initial begin
      reset = 1'b1;
      preload = 1'b0;
      req_addr = '0; req_wdata = '0; req_funct3 = '0;
      na_req_addr = '0; na_req_wdata = '0; na_req_funct3 = '0;
      idle();
      test_reset();
      test_aligned_lw();
      test_byte_half();
      test_lh_misaligned();
      test_lw_misaligned();
      test_sw_misaligned();
      test_reset_mid();
      test_no_misalign();
      test_illegal();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion want finish before 100000");
      $fatal(1);
   end

endmodule
